// File: rtl/pcs_tx_pkg.sv
// rtl/pcs_tx_pkg.sv - shared 40GBASE-R PCS transmit constants, AM byte table and BIP8 helper
package pcs_tx_pkg;

  localparam int PKG_HEAD_W  = 2;
  localparam int PKG_DATA_W  = 64;
  localparam int PKG_BLOCK_W = PKG_HEAD_W + PKG_DATA_W;
  localparam int AM_LANE_N   = 4;

  // header bit0 is transmitted first
  localparam logic [PKG_HEAD_W-1:0] SYNC_CTRL = 2'b01;
  localparam logic [PKG_HEAD_W-1:0] SYNC_DATA = 2'b10;

  localparam logic [7:0] AM_LANE_M [AM_LANE_N][3] = '{
    '{8'h90, 8'h76, 8'h47},
    '{8'hF0, 8'hC4, 8'hE6},
    '{8'hC5, 8'h65, 8'h9B},
    '{8'hA2, 8'h79, 8'h3D}
  };

  // blk = {payload, header}; header bits fold into BIP bits 3 and 4
  function automatic logic [7:0] bip8(input logic [PKG_BLOCK_W-1:0] blk);
    logic [7:0] b;
    b = 8'h00;
    for (int k = 0; k < PKG_DATA_W / 8; k++) begin
      b = b ^ blk[PKG_HEAD_W + 8*k +: 8];
    end
    b[3] = b[3] ^ blk[0];
    b[4] = b[4] ^ blk[1];
    return b;
  endfunction

endpackage

// File: rtl/am_bip_tx.sv
// rtl/am_bip_tx.sv - per-lane running BIP8 accumulator for alignment-marker insertion
module am_bip_tx
  import pcs_tx_pkg::*;
(
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   data_v,
  input  logic                   am_v,
  input  logic [PKG_BLOCK_W-1:0] blk,
  output logic [7:0]             acc
);

  // a marker restarts the accumulation with its own parity
  always_ff @(posedge clk) begin
    if (nreset) begin
      acc <= 8'h00;
    end else if (am_v) begin
      acc <= bip8(blk);
    end else if (data_v) begin
      acc <= acc ^ bip8(blk);
    end
  end

endmodule

// File: rtl/am_insert_tx.sv
// rtl/am_insert_tx.sv - 40GBASE-R transmit alignment-marker insertion across all lanes
module am_insert_tx
  import pcs_tx_pkg::*;
#(
  parameter int LANE_N   = 4,
  parameter int HEAD_W   = 2,
  parameter int DATA_W   = 64,
  parameter int BLOCK_W  = HEAD_W + DATA_W,
  parameter int AM_GAP_N = 16383,
  parameter int CNT_W    = $clog2(AM_GAP_N + 1)
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     valid_i,
  input  logic [LANE_N*HEAD_W-1:0] head_i,
  input  logic [LANE_N*DATA_W-1:0] data_i,
  output logic                     ready_o,
  output logic                     valid_o,
  output logic                     marker_v_o,
  output logic [LANE_N*HEAD_W-1:0] head_o,
  output logic [LANE_N*DATA_W-1:0] data_o
);

  logic             am_pending;
  logic [CNT_W-1:0] cnt;
  logic             data_v;

  logic [LANE_N*HEAD_W-1:0] am_head;
  logic [LANE_N*DATA_W-1:0] am_data;

  assign ready_o = ~am_pending & ~nreset;
  assign data_v  = ~am_pending & valid_i;

  for (genvar l = 0; l < LANE_N; l++) begin : g_lane
    logic [7:0]         bip;
    logic [BLOCK_W-1:0] bip_blk;

    assign am_head[l*HEAD_W +: HEAD_W] = SYNC_CTRL;
    assign am_data[l*DATA_W +: DATA_W] = {
      ~bip, ~AM_LANE_M[l][2], ~AM_LANE_M[l][1], ~AM_LANE_M[l][0],
       bip,  AM_LANE_M[l][2],  AM_LANE_M[l][1],  AM_LANE_M[l][0]
    };

    // the accumulator sees exactly the block that goes to the output register
    assign bip_blk = am_pending
      ? {am_data[l*DATA_W +: DATA_W], am_head[l*HEAD_W +: HEAD_W]}
      : {data_i[l*DATA_W +: DATA_W], head_i[l*HEAD_W +: HEAD_W]};

    am_bip_tx u_bip (
      .clk    (clk),
      .nreset (nreset),
      .data_v (data_v),
      .am_v   (am_pending),
      .blk    (bip_blk),
      .acc    (bip)
    );
  end

  always_ff @(posedge clk) begin
    if (nreset) begin
      valid_o    <= 1'b0;
      marker_v_o <= 1'b0;
      head_o     <= '0;
      data_o     <= '0;
      cnt        <= '0;
      am_pending <= 1'b1;
    end else if (am_pending) begin
      valid_o    <= 1'b1;
      marker_v_o <= 1'b1;
      head_o     <= am_head;
      data_o     <= am_data;
      am_pending <= 1'b0;
    end else if (valid_i) begin
      valid_o    <= 1'b1;
      marker_v_o <= 1'b0;
      head_o     <= head_i;
      data_o     <= data_i;
      if (cnt == CNT_W'(AM_GAP_N - 1)) begin
        cnt        <= '0;
        am_pending <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      valid_o    <= 1'b0;
      marker_v_o <= 1'b0;
    end
  end

endmodule

// File: doc/am_insert_tx.md
# am_insert_tx

Transmit-side alignment-marker insertion for the 40GBASE-R PCS. It sits between the TX scrambler and the per-lane gearboxes, the mirror of the RX alignment-marker lock and removal path. All lanes advance together. Every AM_GAP_N accepted data blocks, it steals one output slot and emits a per-lane alignment marker carrying a running BIP8. It back-pressures the scrambler with `ready_o` during that slot.

## Interface

Parameters:
- `LANE_N`, 4: number of PCS lanes.
- `HEAD_W`, 2: sync header width.
- `DATA_W`, 64: block payload width.
- `BLOCK_W`, HEAD_W+DATA_W: full block width.
- `AM_GAP_N`, 16383: data blocks per lane between markers. Benches override it with a small value.
- `CNT_W`, $clog2(AM_GAP_N+1): counter width.

Ports:
- `clk`, in, 1: the single clock.
- `nreset`, in, 1: synchronous, active-high reset (1 = reset), sampled on `clk`.
- `valid_i`, in, 1: upstream blocks valid on all lanes.
- `head_i`, in, LANE_N*HEAD_W: sync headers; lane l is at [l*HEAD_W +: HEAD_W].
- `data_i`, in, LANE_N*DATA_W: scrambled payloads; lane l is at [l*DATA_W +: DATA_W].
- `ready_o`, out, 1: block accepted when `valid_i & ready_o`.
- `valid_o`, out, 1: output block valid on all lanes.
- `marker_v_o`, out, 1: the current output is an alignment marker.
- `head_o`, out, LANE_N*HEAD_W: output headers.
- `data_o`, out, LANE_N*DATA_W: output payloads.

## Operation

- State:
  - `am_pending` flag.
  - data counter `cnt` (CNT_W bits).
  - one 8-bit BIP accumulator per lane.
- `ready_o = ~am_pending & ~nreset`. This is combinational from registers and the reset input only, and never depends on `valid_i`.
- Data slot (`am_pending=0` and `valid_i=1`):
  - The input block is registered to the outputs.
  - `valid_o=1`, `marker_v_o=0`.
  - `cnt <= cnt+1`.
  - If `cnt == AM_GAP_N-1`, set `am_pending` and `cnt <= 0`.
- Idle (`am_pending=0`, `valid_i=0`): `valid_o=0`, `marker_v_o=0`; `cnt`, BIP and data outputs hold.
- Marker slot (`am_pending=1`):
  - Emit the marker independently of `valid_i`: `valid_o=1`, `marker_v_o=1`, clear `am_pending`.
  - The upstream block stays held, because `ready_o=0`.
- Marker block per lane:
  - Control header: head bit0=1, bit1=0 (bit0 is sent first).
  - Payload bytes M0, M1, M2, BIP3, M4, M5, M6, BIP7, with byte k at `data[8k+7:8k]`.
  - M4..M6 = ~M0..M2.
  - BIP3 = lane accumulator value; BIP7 = ~BIP3.
- Per-lane M0/M1/M2 values:
  - Lane 0: 0x90/0x76/0x47.
  - Lane 1: 0xF0/0xC4/0xE6.
  - Lane 2: 0xC5/0x65/0x9B.
  - Lane 3: 0xA2/0x79/0x3D.
- BIP definition: BIP bit j = XOR of payload bit j of every byte, plus header bit0 for j=3 and header bit1 for j=4.
- BIP coverage: every block output on the lane from the previous marker inclusive to the current marker exclusive.
- BIP update:
  - On a data slot: `acc <= acc ^ bip(block)`.
  - On a marker slot: `acc <= bip(marker block)`. This value is always 0x08, because the marker bytes XOR to 0.

## Timing

- Latency is one cycle from acceptance to output. Outputs are registered and there is no combinational path from `data_i` to `data_o`.
- While `nreset=1`, each following clock edge sets:
  - `valid_o=0`, `marker_v_o=0`, `head_o=0`, `data_o=0`.
  - `cnt=0`, all BIP accumulators 0x00.
  - `am_pending=1`.
- First cycle after reset:
  - `ready_o=0`.
  - The first output is a marker with BIP3=0x00 and BIP7=0xFF.
- Steady state with `valid_i` constantly 1: `ready_o` is low for exactly 1 cycle in every AM_GAP_N+1.
  - Output pattern: marker, then AM_GAP_N data blocks, repeating.
- Reset mid-operation: discards the count and BIP and restarts as above. A block presented in the reset cycle is not accepted.
- No downstream back-pressure exists; `valid_o` is the only qualifier.

## Structure

- Shared package `pcs_tx_pkg` holds:
  - sync header constants `SYNC_CTRL` and `SYNC_DATA`.
  - AM byte table `AM_LANE_M[LANE_N][3]`.
  - function `bip8(block)`.
- Sub-module `am_bip_tx`, instantiated once per lane:
  - Inputs: `clk`, `nreset`, `data_v`, `am_v`, block.
  - Output: 8-bit accumulator.
- The top holds `am_pending`, `cnt`, marker assembly and the output register.

## Test plan

- Reset-release test:
  - Stimulus: AM_GAP_N=4, `valid_i` held at 1.
  - `ready_o` pattern: 0,1,1,1,1,0,...
  - First output: lane-0 payload bytes 90 76 47 00 6F 89 B8 FF, `marker_v_o=1`.
- BIP test:
  - Stimulus: after the first marker, 4 all-zero payloads with data header (bit0=0, bit1=1).
  - Second marker: BIP3=0x08, BIP7=0xF7 on every lane.
- Back-pressure test:
  - Stimulus: `valid_i` toggled 1,0,1,0,...
  - The marker appears only after exactly 4 accepted blocks.
  - Idle cycles give `valid_o=0` and leave the count unchanged.
- Hold test:
  - Stimulus: block B presented during a marker cycle (`ready_o=0`).
  - B is emitted unchanged in the cycle after the marker, and is counted once.
- Mid-run reset test:
  - Stimulus: `nreset` pulsed after 2 data blocks.
  - Next output is a marker with BIP3=0x00, followed by 4 data blocks before the following marker.
- Lane marker test:
  - Lanes 1/2/3 M0..M2 are F0 C4 E6 / C5 65 9B / A2 79 3D.
  - M4..M6 are their bitwise inverses.
  - Header is control on all lanes.
